hilo_muldiv_unit: RTL and testbench

Iterative multiply/divide unit with the architectural HI/LO register pair for the MIPS datapath. It consumes the ALU control code and the HI/LO write strobe produced by the control units. On mult, multu, div and divu it runs a 32-step shift-add or shift-subtract sequence and writes HI/LO. It raises `busy` so the control FSM can hold the PC and pipeline until the result commits.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_step.sv | 41 ++++
 rtl/hilo_muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the HI/LO multiply/divide unit.
package muldiv_pkg;

   localparam int unsigned ALU_CTRL_W = 5;

   localparam logic [ALU_CTRL_W-1:0] MULT  = 5'b01001;
   localparam logic [ALU_CTRL_W-1:0] MULTU = 5'b01110;
   localparam logic [ALU_CTRL_W-1:0] DIV   = 5'b01010;
   localparam logic [ALU_CTRL_W-1:0] DIVU  = 5'b01101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2
   } state_e;

   function automatic logic is_valid_op(input logic [ALU_CTRL_W-1:0] op);
      return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
   endfunction

   function automatic logic is_div_op(input logic [ALU_CTRL_W-1:0] op);
      return (op == DIV) || (op == DIVU);
   endfunction

   function automatic logic is_signed_op(input logic [ALU_CTRL_W-1:0] op);
      return (op == MULT) || (op == DIV);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// Accumulator layout is {upper (WIDTH+1 bits), lower (WIDTH bits)}.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [ALU_CTRL_W-1:0] op_i,
   input  logic [2*WIDTH:0]      acc_i,
   input  logic [WIDTH-1:0]      operand_i,
   output logic [2*WIDTH:0]      acc_o
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [2*WIDTH:0] shl;

   always_comb begin
      sum   = '0;
      diff  = '0;
      shl   = '0;
      acc_o = acc_i;
      if (is_div_op(op_i)) begin
         // Remainder stays below 2*divisor after the shift, so WIDTH+1 bits suffice.
         shl   = {acc_i[2*WIDTH-1:0], 1'b0};
         diff  = shl[2*WIDTH:WIDTH] - {1'b0, operand_i};
         acc_o = shl;
         if (shl[2*WIDTH:WIDTH] >= {1'b0, operand_i}) begin
            acc_o[2*WIDTH:WIDTH] = diff;
            acc_o[0]             = 1'b1;
         end
      end else begin
         sum = acc_i[2*WIDTH:WIDTH] + {1'b0, operand_i};
         if (acc_i[0]) begin
            acc_o = {sum, acc_i[WIDTH-1:0]};
         end
         acc_o = acc_o >> 1;
      end
   end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative mult/multu/div/divu unit owning the architectural HI/LO pair.
// Fixed 33-cycle latency: WIDTH magnitude steps then one sign-fix/commit cycle.
module hilo_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  hiloWrite,
   input  logic [ALU_CTRL_W-1:0] aluCtrl,
   input  logic [WIDTH-1:0]      srcA,
   input  logic [WIDTH-1:0]      srcB,
   output logic [WIDTH-1:0]      hi,
   output logic [WIDTH-1:0]      lo,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam int unsigned ACC_W = 2 * WIDTH + 1;

   state_e                  state_q;
   logic [ALU_CTRL_W-1:0]   op_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [ACC_W-1:0]        acc_q;
   logic [ACC_W-1:0]        acc_d;
   logic [WIDTH-1:0]        opnd_q;
   logic                    neg_a_q;
   logic                    neg_b_q;
   logic                    b_zero_q;
   logic [WIDTH-1:0]        hi_q;
   logic [WIDTH-1:0]        lo_q;
   logic                    busy_q;
   logic                    done_q;

   logic                    in_signed;
   logic [WIDTH-1:0]        abs_a;
   logic [WIDTH-1:0]        abs_b;
   logic                    fix_signed;
   logic [2*WIDTH-1:0]      prod;
   logic [WIDTH-1:0]        quo;
   logic [WIDTH-1:0]        rem;
   logic [WIDTH-1:0]        hi_d;
   logic [WIDTH-1:0]        lo_d;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .op_i      (op_q),
      .acc_i     (acc_q),
      .operand_i (opnd_q),
      .acc_o     (acc_d)
   );

   // Operand magnitudes for the unsigned core.
   always_comb begin
      in_signed = is_signed_op(aluCtrl);
      abs_a     = (in_signed && srcA[WIDTH-1]) ? -srcA : srcA;
      abs_b     = (in_signed && srcB[WIDTH-1]) ? -srcB : srcB;
   end

   // Sign correction; a zero divisor keeps the all-ones quotient the core produces.
   always_comb begin
      fix_signed = is_signed_op(op_q);
      prod       = acc_q[2*WIDTH-1:0];
      quo        = acc_q[WIDTH-1:0];
      rem        = acc_q[2*WIDTH-1:WIDTH];
      if (fix_signed && (neg_a_q ^ neg_b_q)) begin
         prod = -prod;
      end
      if (fix_signed && (neg_a_q ^ neg_b_q) && !b_zero_q) begin
         quo = -quo;
      end
      if (fix_signed && neg_a_q) begin
         rem = -rem;
      end
      if (is_div_op(op_q)) begin
         hi_d = rem;
         lo_d = quo;
      end else begin
         hi_d = prod[2*WIDTH-1:WIDTH];
         lo_d = prod[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_q     <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         b_zero_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (hiloWrite && is_valid_op(aluCtrl)) begin
                  op_q     <= aluCtrl;
                  neg_a_q  <= in_signed & srcA[WIDTH-1];
                  neg_b_q  <= in_signed & srcB[WIDTH-1];
                  b_zero_q <= (srcB == '0);
                  if (is_div_op(aluCtrl)) begin
                     acc_q  <= {{(WIDTH+1){1'b0}}, abs_a};
                     opnd_q <= abs_b;
                  end else begin
                     acc_q  <= {{(WIDTH+1){1'b0}}, abs_b};
                     opnd_q <= abs_a;
                  end
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ITER;
               end
            end
            ITER: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               hi_q    <= hi_d;
               lo_q    <= lo_d;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               cnt_q   <= '0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: directed ops push expected HI/LO and
// completion cycle; a negedge monitor pops and compares on every done pulse.
module tb_hilo_muldiv_unit;
   import muldiv_pkg::*;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
      string       name;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        hiloWrite;
   logic [4:0]  aluCtrl;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   exp_t sb_q[$];

   hilo_muldiv_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .hiloWrite (hiloWrite),
      .aluCtrl   (aluCtrl),
      .srcA      (srcA),
      .srcB      (srcB),
      .hi        (hi),
      .lo        (lo),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk({e.name, "_hi"}, hi, e.hi);
            chk({e.name, "_lo"}, lo, e.lo);
            chk({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
         end
      end
   end

   // Called at a negedge; returns at the negedge where done is seen.
   // glitch_at >= 0 re-pulses hiloWrite that many cycles into the operation.
   task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input int glitch_at);
      exp_t e;
      logic busy_ok;
      e.hi = eh; e.lo = el; e.cyc = cyc + 34; e.name = name;
      sb_q.push_back(e);
      hiloWrite = 1'b1; aluCtrl = op; srcA = a; srcB = b;
      @(negedge clk);
      hiloWrite = 1'b0;
      srcA = ~a; srcB = b ^ 32'h5A5A_A5A5;
      busy_ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) break;
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (i == glitch_at) begin
            hiloWrite = 1'b1; aluCtrl = MULTU; srcA = 32'h3; srcB = 32'h3;
         end else begin
            hiloWrite = 1'b0;
         end
         @(negedge clk);
      end
      hiloWrite = 1'b0;
      chk({name, "_busy_held"}, 32'(busy_ok), 32'd1);
      if (done !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: got no done within 40 cycles expected done", name);
      end else begin
         chk({name, "_busy_drop"}, 32'(busy), 32'd0);
      end
   endtask

   initial begin
      rst_n = 1'b0; hiloWrite = 1'b0; aluCtrl = '0; srcA = '0; srcB = '0;
      repeat (2) @(negedge clk);
      chk("reset_hi", hi, 32'h0);
      chk("reset_lo", lo, 32'h0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Back-to-back directed vectors
      run_op("mult_neg1x2",  MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, -1);
      run_op("multu_max_x2", MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, -1);
      run_op("div_m7_2",     DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
      run_op("divu_7_2",     DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, -1);
      run_op("divu_by0",     DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, -1);
      run_op("div_ovf",      DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, -1);
      run_op("div_m7_by0",   DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, -1);
      run_op("div_7_m2",     DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, -1);
      run_op("mult_m3_m7",   MULT,  32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h0000_0000, 32'h0000_0015, -1);
      run_op("multu_maxsq",  MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -1);
      run_op("multu_2p32",   MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, -1);

      // Second start mid-operation must be ignored
      run_op("glitch_divu",  DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 9);
      repeat (3) @(negedge clk);

      // Invalid code does not start anything
      hiloWrite = 1'b1; aluCtrl = 5'b00000; srcA = 32'h9; srcB = 32'h9;
      @(negedge clk);
      hiloWrite = 1'b0;
      chk("invalid_busy", 32'(busy), 32'd0);
      repeat (36) @(negedge clk);
      chk("invalid_busy_late", 32'(busy), 32'd0);
      chk("invalid_hi_kept", hi, 32'h0000_0002);
      chk("invalid_lo_kept", lo, 32'h0000_000E);

      // Reset in the middle of an operation
      hiloWrite = 1'b1; aluCtrl = MULTU; srcA = 32'h1234_5678; srcB = 32'h10;
      @(negedge clk);
      hiloWrite = 1'b0;
      repeat (10) @(negedge clk);
      chk("abort_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_hi", hi, 32'h0);
      chk("abort_lo", lo, 32'h0);
      repeat (3) @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("abort_idle_busy", 32'(busy), 32'd0);
      run_op("after_abort",  MULT,  32'h0000_0064, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FF38, -1);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
